gate_result_checker: RTL and testbench

- Synthesizable response checker for the two-input logic-gate block; it is the receiving end of the gate stimulus flow.
- Accepts {a, b, seven gate outputs} samples over a valid/ready handshake and compares each against a golden model.
- Counts mismatches, records the first failing vector and tracks input-combination coverage.
- Reports pass/fail once a programmed number of samples has been checked; sits beside the gate block in on-chip self-test.

---
 rtl/gate_result_checker_pkg.sv | 34 +++
 rtl/gate_result_checker_if.sv | 14 +
 rtl/gate_ref_model.sv | 11 +
 rtl/gate_result_checker.sv | 122 ++++++++++++
 tb/tb_gate_result_checker.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_result_checker_pkg.sv
// Shared definitions for the gate response checker: gate bit positions,
// checker FSM states and the golden truth function for the two-input gate block.
package gate_chk_pkg;

    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NOT  = 2;
    localparam int GATE_XOR  = 3;
    localparam int GATE_XNOR = 4;
    localparam int GATE_NAND = 5;
    localparam int GATE_NOR  = 6;
    localparam int NUM_GATES = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [NUM_GATES-1:0] gate_expected(input logic a, input logic b);
        logic [NUM_GATES-1:0] e;
        e            = '0;
        e[GATE_AND]  = a & b;
        e[GATE_OR]   = a | b;
        e[GATE_NOT]  = ~a;
        e[GATE_XOR]  = a ^ b;
        e[GATE_XNOR] = ~(a ^ b);
        e[GATE_NAND] = ~(a & b);
        e[GATE_NOR]  = ~(a | b);
        return e;
    endfunction

endpackage

// File: rtl/gate_result_checker_if.sv
// Sample stream into the checker: stimulus {a, b} plus the seven observed gate outputs.
// Valid/ready handshake; the source holds the sample until in_ready is seen.
interface gate_result_checker_if;
    import gate_chk_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic                 a;
    logic                 b;
    logic [NUM_GATES-1:0] gate_y;

    modport master (output in_valid, a, b, gate_y, input  in_ready);
    modport slave  (input  in_valid, a, b, gate_y, output in_ready);
endinterface

// File: rtl/gate_ref_model.sv
// Combinational golden model of the two-input gate block: {a, b} -> expected outputs.
// Latency: 0 cycles. Backpressure: none (pure function).
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] expected
);
    assign expected = gate_expected(a, b);
endmodule

// File: rtl/gate_result_checker.sv
// Checks gate-block samples against the golden model; counts errors, logs first failure, tracks coverage.
// Latency: results commit one cycle after a sample transfers; done one cycle after the last transfer.
// Backpressure: in_ready only in RUN, 1 sample/cycle; samples outside RUN are left with the source.
module gate_result_checker
    import gate_chk_pkg::*;
#(
    parameter int NUM_VECTORS = 4,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    gate_result_checker_if.slave smp,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_count,
    output logic [NUM_GATES-1:0] mismatch,
    output logic [3:0]           coverage,
    output logic                 first_fail_valid,
    output logic [8:0]           first_fail_vec
);
    localparam int SMP_W = $clog2(NUM_VECTORS + 1);

    state_t               state, state_nxt;
    logic [SMP_W-1:0]     smp_cnt;
    logic                 xfer;
    logic                 last_xfer;
    logic                 clear;

    logic                 cap_vld;
    logic                 cap_a;
    logic                 cap_b;
    logic [NUM_GATES-1:0] cap_y;
    logic [NUM_GATES-1:0] expected;
    logic [NUM_GATES-1:0] cmp_mask;

    assign xfer      = smp.in_valid & smp.in_ready;
    assign last_xfer = xfer && (smp_cnt == SMP_W'(NUM_VECTORS - 1));
    // start only has effect when no run is in flight
    assign clear     = start && (state == ST_IDLE || state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        smp.in_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                smp.in_ready = 1'b1;
                busy         = 1'b1;
                if (last_xfer) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (cap_vld) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
        pass = done && (err_count == '0) && (&coverage);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cap_vld <= 1'b0;
            cap_a   <= 1'b0;
            cap_b   <= 1'b0;
            cap_y   <= '0;
            smp_cnt <= '0;
        end else begin
            cap_vld <= xfer;
            if (xfer) begin
                cap_a   <= smp.a;
                cap_b   <= smp.b;
                cap_y   <= smp.gate_y;
                smp_cnt <= smp_cnt + SMP_W'(1);
            end
        end
    end

    gate_ref_model u_ref (
        .a        (cap_a),
        .b        (cap_b),
        .expected (expected)
    );

    assign cmp_mask = expected ^ cap_y;

    // Compare stage only acts on captured samples, so idle bus values never reach the results.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_count        <= '0;
            mismatch         <= '0;
            coverage         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (cap_vld) begin
            mismatch                <= cmp_mask;
            coverage[{cap_a, cap_b}] <= 1'b1;
            if (|cmp_mask) begin
                if (err_count != '1) err_count <= err_count + CNT_W'(1);
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_vec   <= {cap_a, cap_b, cap_y};
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_result_checker.sv
module tb_gate_result_checker;
    import gate_chk_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_a, start_b;
    gate_result_checker_if ifa ();
    gate_result_checker_if ifb ();

    logic       busy_a, done_a, pass_a, ffv_a;
    logic [7:0] err_a;
    logic [6:0] mm_a;
    logic [3:0] cov_a;
    logic [8:0] ffvec_a;

    logic       busy_b, done_b, pass_b, ffv_b;
    logic [1:0] err_b;
    logic [6:0] mm_b;
    logic [3:0] cov_b;
    logic [8:0] ffvec_b;

    logic       ra, rb;
    logic [6:0] rexp;

    gate_result_checker #(.NUM_VECTORS(4), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .smp(ifa.slave),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .mismatch(mm_a), .coverage(cov_a), .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
    );

    gate_result_checker #(.NUM_VECTORS(6), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .smp(ifb.slave),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .mismatch(mm_b), .coverage(cov_b), .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
    );

    gate_ref_model u_ref_tb (.a(ra), .b(rb), .expected(rexp));

    int n_checks = 0;
    int n_err    = 0;

    // Reference state for DUT A, rebuilt from the gate truth rules per run.
    int         m_err;
    logic [3:0] m_cov;
    logic       m_ffv;
    logic [8:0] m_ffvec;
    logic [6:0] m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Gate truths from counting ones in {a,b}: bit order and,or,not,xor,xnor,nand,nor.
    function automatic logic [6:0] golden(input logic a, input logic b);
        int ones;
        logic [6:0] g;
        ones = int'(a) + int'(b);
        g[0] = (ones == 2);
        g[1] = (ones >= 1);
        g[2] = (a == 1'b0);
        g[3] = (ones == 1);
        g[4] = (ones != 1);
        g[5] = (ones != 2);
        g[6] = (ones == 0);
        return g;
    endfunction

    task automatic model_clear();
        m_err = 0; m_cov = '0; m_ffv = 1'b0; m_ffvec = '0; m_last = '0;
    endtask

    task automatic model_push(input logic a, input logic b, input logic [6:0] y);
        logic [6:0] mm;
        mm = golden(a, b) ^ y;
        m_cov[int'(a) * 2 + int'(b)] = 1'b1;
        if (mm != 0) begin
            m_err++;
            if (!m_ffv) begin m_ffv = 1'b1; m_ffvec = {a, b, y}; end
        end
        m_last = mm;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rdy"},   ifa.in_ready, 0);
        chk({tag, "_busy"},  busy_a, 0);
        chk({tag, "_done"},  done_a, 0);
        chk({tag, "_pass"},  pass_a, 0);
        chk({tag, "_err"},   err_a, 0);
        chk({tag, "_mm"},    mm_a, 0);
        chk({tag, "_cov"},   cov_a, 0);
        chk({tag, "_ffv"},   ffv_a, 0);
        chk({tag, "_ffvec"}, ffvec_a, 0);
    endtask

    task automatic do_start(input bit fresh);
        @(negedge clk);
        start_a = 1'b1;
        if (fresh) model_clear();
        @(negedge clk);
        start_a = 1'b0;
        chk("start_rdy",  ifa.in_ready, 1);
        chk("start_busy", busy_a, 1);
    endtask

    // Presents a sample (after gap idle cycles) and returns at the negedge following its transfer.
    task automatic send(input logic a, input logic b, input logic [6:0] y, input int gap);
        logic took;
        took = 1'b0;
        repeat (gap) @(negedge clk);
        ifa.in_valid = 1'b1; ifa.a = a; ifa.b = b; ifa.gate_y = y;
        for (int t = 0; t < 20 && !took; t++) begin
            took = ifa.in_ready;
            @(negedge clk);
        end
        if (took) model_push(a, b, y);
        else chk("send_timeout", ifa.in_ready, 1);
        ifa.in_valid = 1'b0;
    endtask

    // Called at the negedge after the last transfer: one cycle of DRAIN, then DONE.
    task automatic check_results(input string tag);
        chk({tag, "_drain_busy"}, busy_a, 1);
        chk({tag, "_drain_done"}, done_a, 0);
        @(negedge clk);
        chk({tag, "_done"},  done_a, 1);
        chk({tag, "_busy"},  busy_a, 0);
        chk({tag, "_rdy"},   ifa.in_ready, 0);
        chk({tag, "_err"},   err_a, (m_err > 255) ? 255 : m_err);
        chk({tag, "_cov"},   cov_a, m_cov);
        chk({tag, "_ffv"},   ffv_a, m_ffv);
        chk({tag, "_ffvec"}, ffvec_a, m_ffvec);
        chk({tag, "_mm"},    mm_a, m_last);
        chk({tag, "_pass"},  pass_a, (m_err == 0 && m_cov == 4'hF) ? 1 : 0);
    endtask

    initial begin
        logic [1:0] ab;
        logic [6:0] y, msk;
        int nb_wrong;
        logic [8:0] b_first;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        ifa.in_valid = 1'b0; ifa.a = 1'b0; ifa.b = 1'b0; ifa.gate_y = '0;
        ifb.in_valid = 1'b0; ifb.a = 1'b0; ifb.b = 1'b0; ifb.gate_y = '0;
        ra = 1'b0; rb = 1'b0;
        model_clear();

        // Golden submodule against the bench's own truth rules
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            ra = ab[1]; rb = ab[0];
            #1;
            chk("ref_model", rexp, golden(ab[1], ab[0]));
        end

        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b0;

        // in_valid held in IDLE must not be consumed
        ifa.in_valid = 1'b1; ifa.gate_y = 7'h7F;
        repeat (3) @(negedge clk);
        chk("idle_rdy", ifa.in_ready, 0);
        chk("idle_cov", cov_a, 0);
        ifa.in_valid = 1'b0;

        // All four combinations, correct outputs
        do_start(1);
        send(0, 0, golden(0, 0), 0);
        send(0, 1, golden(0, 1), 0);
        send(1, 0, golden(1, 0), 0);
        send(1, 1, golden(1, 1), 0);
        check_results("all4");

        // xor bit flipped on {1,0}
        do_start(1);
        send(0, 0, golden(0, 0), 0);
        send(0, 1, golden(0, 1), 0);
        send(1, 0, golden(1, 0) ^ 7'b0001000, 0);
        send(1, 1, golden(1, 1), 0);
        chk("xor_mm_next", mm_a, 7'b0001000);
        chk("xor_err_next", err_a, 1);
        chk("xor_ffvec_next", ffvec_a, {1'b1, 1'b0, golden(1, 0) ^ 7'b0001000});
        check_results("xorflip");

        // Partial coverage
        do_start(1);
        send(0, 0, golden(0, 0), 0);
        send(0, 0, golden(0, 0), 0);
        send(0, 1, golden(0, 1), 0);
        send(0, 1, golden(0, 1), 0);
        check_results("partcov");

        // Gaps, start ignored mid-run, in_valid held through DRAIN/DONE
        do_start(1);
        send(1, 1, golden(1, 1), 2);
        send(0, 1, golden(0, 1) ^ 7'b1000001, 1);
        do_start(0);
        send(1, 0, golden(1, 0), 3);
        send(0, 0, golden(0, 0) ^ 7'b0000100, 1);
        ifa.in_valid = 1'b1; ifa.a = 1'b1; ifa.b = 1'b1; ifa.gate_y = 7'h00;
        check_results("gaps");
        @(negedge clk);
        chk("done_hold_err", err_a, m_err);
        chk("done_hold_done", done_a, 1);
        ifa.in_valid = 1'b0;

        // Reset mid-run
        do_start(1);
        send(1, 0, golden(1, 0) ^ 7'b0000010, 0);
        send(1, 1, golden(1, 1), 0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_values("midrst");
        rst = 1'b0;
        do_start(1);
        send(1, 1, golden(1, 1), 0);
        send(1, 0, golden(1, 0), 0);
        send(0, 1, golden(0, 1), 0);
        send(0, 0, golden(0, 0), 0);
        check_results("afterrst");

        // rst and start together: rst wins
        rst = 1'b1; start_a = 1'b1;
        @(negedge clk);
        rst = 1'b0; start_a = 1'b0;
        chk("rst_start_busy", busy_a, 0);
        chk("rst_start_rdy", ifa.in_ready, 0);

        // Randomized runs
        for (int r = 0; r < 20; r++) begin
            do_start(1);
            for (int k = 0; k < 4; k++) begin
                ab = 2'($urandom_range(0, 3));
                y  = golden(ab[1], ab[0]);
                if ($urandom_range(0, 2) == 0) y = y ^ 7'($urandom_range(1, 127));
                send(ab[1], ab[0], y, $urandom_range(0, 2));
            end
            check_results("rand");
        end

        // Saturation: CNT_W=2, NUM_VECTORS=6, every sample wrong
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        nb_wrong = 0;
        b_first  = '0;
        for (int k = 0; k < 6; k++) begin
            ab  = 2'($urandom_range(0, 3));
            msk = 7'($urandom_range(1, 127));
            y   = golden(ab[1], ab[0]) ^ msk;
            if (k == 0) b_first = {ab[1], ab[0], y};
            nb_wrong++;
            ifb.in_valid = 1'b1; ifb.a = ab[1]; ifb.b = ab[0]; ifb.gate_y = y;
            chk("sat_rdy", ifb.in_ready, 1);
            @(negedge clk);
        end
        ifb.in_valid = 1'b0;
        chk("sat_drain_done", done_b, 0);
        @(negedge clk);
        chk("sat_done",  done_b, 1);
        chk("sat_err",   err_b, (nb_wrong > 3) ? 3 : nb_wrong);
        chk("sat_ffv",   ffv_b, 1);
        chk("sat_ffvec", ffvec_b, b_first);
        chk("sat_pass",  pass_b, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
